reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Architectural integer register file that receives the write-back stage's result, destination and write-enable, and serves two combinational read ports to decode.
- Also tracks in-flight writers per register, so decode can detect RAW hazards on long-latency producers such as cache misses.
- The scoreboard is incremented at issue, decremented when the write-back actually lands, and cleared on flush.

Parameters:
NUM_REGS, 32, number of architectural registers (x0 hardwired to zero)
MAX_INFLIGHT, 4, maximum outstanding writers tracked per register
CNT_W, $clog2(MAX_INFLIGHT+1), width of each per-register pending counter (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush_in  in  1  pipeline flush; clears all pending counters
rs1_addr_in  in  REG_BITS  read port 1 address
rs2_addr_in  in  REG_BITS  read port 2 address
rs1_data_out  out  XLEN  read port 1 data (bypassed)
rs2_data_out  out  XLEN  read port 2 data (bypassed)
rs1_busy_out  out  1  rs1 has an unresolved pending writer
rs2_busy_out  out  1  rs2 has an unresolved pending writer
issue_valid_in  in  1  decode issues an instruction this cycle
issue_reg_write_in  in  1  the issued instruction writes a register
issue_rd_in  in  REG_BITS  issued destination
issue_ready_out  out  1  issue_rd counter below MAX_INFLIGHT
wb_reg_write_in  in  1  write-back enable (from write-back reg_write)
wb_rd_in  in  REG_BITS  write-back destination
wb_data_in  in  XLEN  write-back result
sb_error_out  out  1  sticky: decrement of a zero counter observed

Behaviour:
- Reset (synchronous, active-high):
  - All registers := 0.
  - All counters := 0.
  - sb_error_out := 0.
  - Reset overrides flush and all other inputs in the same cycle.
- Write:
  - When wb_reg_write_in && wb_rd_in != 0, regs[wb_rd_in] := wb_data_in at posedge clk.
  - Writes to x0 are dropped.
- Read (combinational):
  - Address 0 returns 0.
  - Else, if wb_reg_write_in && wb_rd_in == addr, return wb_data_in (write-through bypass, zero-cycle).
  - Else return regs[addr].
- Issue handshake:
  - An issue is accepted only when issue_valid_in && issue_reg_write_in && issue_rd_in != 0 && issue_ready_out.
  - issue_ready_out = (cnt[issue_rd_in] != MAX_INFLIGHT); it is 1 for rd = 0 and 1 when issue_reg_write_in = 0.
  - Decode must hold the instruction while issue_ready_out = 0.
- Counter update per register r, each cycle (no flush):
  - inc = accepted issue to r.
  - dec = wb_reg_write_in && wb_rd_in == r && r != 0.
  - inc && !dec: cnt+1. dec && !inc: cnt-1. Both or neither: unchanged.
  - Underflow (dec with cnt == 0 and !inc): cnt stays 0 and sb_error_out := 1, sticky until reset.
  - cnt never exceeds MAX_INFLIGHT; the handshake guarantees this.
- Busy:
  - rsN_busy_out = (addr != 0) && (cnt[addr] > (writing-back-this-cycle-to-addr ? 1 : 0)).
  - The last writer landing this cycle is resolved by the bypass, so it is not busy.
- Flush:
  - All counters := 0 next cycle.
  - A write-back presented in the same cycle still writes the array and bypasses, but does not decrement and does not raise sb_error.
  - An issue in the flush cycle is discarded.
- Latency:
  - Array write and counter update take effect at the next edge.
  - Reads, busy and issue_ready_out are combinational on current state plus bypass.

Decomposition:
- brisc_pkg already supplies XLEN and REG_BITS.
- Add NUM_REGS and MAX_INFLIGHT to brisc_pkg as shared constants, so that the hazard unit and decode agree on them.
- One sub-module, reg_pending_cnt, holds a single per-register saturating up/down counter with inc, dec, clr and an underflow flag; it is instantiated NUM_REGS-1 times (x0 excluded).

Test Plan:
- Reset, then read x0..x31 -> all read 0, no busy, issue_ready_out = 1, sb_error_out = 0.
- Issue rd = 5, then wb rd = 5 data 0xDEADBEEF one cycle later, reading rs1 = 5 in the wb cycle:
  - rs1_data_out = 0xDEADBEEF (bypass) and rs1_busy_out = 0.
  - Next cycle the array holds 0xDEADBEEF.
- Issue rd = 7 four times with no wb:
  - issue_ready_out drops to 0 for rd = 7 and stays 1 for rd = 8.
  - A 5th issue is not counted; four wb writes to 7 return cnt to 0 and clear busy.
- Same-cycle issue rd = 3 and wb rd = 3 while cnt = 1 -> cnt stays 1, rs1 = 3 busy next cycle.
- Write-back to x0 with data 0x1234 -> rs1 = 0 reads 0, no counter change, sb_error_out stays 0.
- Issue rd = 9 twice, then flush_in with concurrent wb rd = 9 data 0x55:
  - All counters are 0 and regs[9] = 0x55 next cycle, sb_error_out = 0.
  - A later wb to 9 sets sb_error_out = 1.

Source files
------------

// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared core constants for the integer datapath
package brisc_pkg;

    localparam int XLEN         = 32;
    localparam int REG_BITS     = 5;
    localparam int NUM_REGS     = 32;
    localparam int MAX_INFLIGHT = 4;

endpackage

// File: rtl/reg_pending_cnt.sv
// rtl/reg_pending_cnt.sv - per-register pending-writer up/down counter with underflow flag
module reg_pending_cnt
    import brisc_pkg::*;
#(
    parameter int MAX_CNT = 4,
    parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; clear wins over both.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != CNT_W'(MAX_CNT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with write-through bypass and pending-writer scoreboard
module reg_file_sb
    import brisc_pkg::*;
#(
    parameter int NUM_REGS     = brisc_pkg::NUM_REGS,
    parameter int MAX_INFLIGHT = brisc_pkg::MAX_INFLIGHT,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_in,
    input  logic [REG_BITS-1:0] rs1_addr_in,
    input  logic [REG_BITS-1:0] rs2_addr_in,
    output logic [XLEN-1:0]     rs1_data_out,
    output logic [XLEN-1:0]     rs2_data_out,
    output logic                rs1_busy_out,
    output logic                rs2_busy_out,
    input  logic                issue_valid_in,
    input  logic                issue_reg_write_in,
    input  logic [REG_BITS-1:0] issue_rd_in,
    output logic                issue_ready_out,
    input  logic                wb_reg_write_in,
    input  logic [REG_BITS-1:0] wb_rd_in,
    input  logic [XLEN-1:0]     wb_data_in,
    output logic                sb_error_out
);

    logic [XLEN-1:0]  regs_q [NUM_REGS];
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0] uf;
    logic             sb_error_q;
    logic             sb_error_d;
    logic             issue_acc;
    logic             wb_hit1;
    logic             wb_hit2;

    assign cnt[0] = '0;
    assign uf[0]  = 1'b0;

    assign issue_ready_out = !issue_reg_write_in || (cnt[issue_rd_in] != CNT_W'(MAX_INFLIGHT));
    assign issue_acc = issue_valid_in && issue_reg_write_in && (issue_rd_in != '0)
                     && issue_ready_out && !flush_in;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_pending_cnt #(
            .MAX_CNT (MAX_INFLIGHT),
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .clr_i       (flush_in),
            .inc_i       (issue_acc && (issue_rd_in == REG_BITS'(r))),
            .dec_i       (wb_reg_write_in && (wb_rd_in == REG_BITS'(r)) && !flush_in),
            .cnt_o       (cnt[r]),
            .underflow_o (uf[r])
        );
    end

    // The write landing this cycle is forwarded, so it no longer counts as pending.
    assign wb_hit1 = wb_reg_write_in && (wb_rd_in == rs1_addr_in);
    assign wb_hit2 = wb_reg_write_in && (wb_rd_in == rs2_addr_in);

    assign rs1_data_out = (rs1_addr_in == '0) ? '0 : (wb_hit1 ? wb_data_in : regs_q[rs1_addr_in]);
    assign rs2_data_out = (rs2_addr_in == '0) ? '0 : (wb_hit2 ? wb_data_in : regs_q[rs2_addr_in]);

    assign rs1_busy_out = (rs1_addr_in != '0) &&
                          (wb_hit1 ? (cnt[rs1_addr_in] > CNT_W'(1)) : (cnt[rs1_addr_in] != '0));
    assign rs2_busy_out = (rs2_addr_in != '0) &&
                          (wb_hit2 ? (cnt[rs2_addr_in] > CNT_W'(1)) : (cnt[rs2_addr_in] != '0));

    assign sb_error_d = sb_error_q || (|uf);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_error_q <= 1'b0;
        end else begin
            if (wb_reg_write_in && (wb_rd_in != '0)) begin
                regs_q[wb_rd_in] <= wb_data_in;
            end
            sb_error_q <= sb_error_d;
        end
    end

    assign sb_error_out = sb_error_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and random checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;
    import brisc_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush_in;
    logic [REG_BITS-1:0] rs1_addr_in, rs2_addr_in;
    logic [XLEN-1:0]     rs1_data_out, rs2_data_out;
    logic                rs1_busy_out, rs2_busy_out;
    logic                issue_valid_in, issue_reg_write_in;
    logic [REG_BITS-1:0] issue_rd_in;
    logic                issue_ready_out;
    logic                wb_reg_write_in;
    logic [REG_BITS-1:0] wb_rd_in;
    logic [XLEN-1:0]     wb_data_in;
    logic                sb_error_out;

    reg_file_sb dut (
        .clk                (clk),
        .reset              (reset),
        .flush_in           (flush_in),
        .rs1_addr_in        (rs1_addr_in),
        .rs2_addr_in        (rs2_addr_in),
        .rs1_data_out       (rs1_data_out),
        .rs2_data_out       (rs2_data_out),
        .rs1_busy_out       (rs1_busy_out),
        .rs2_busy_out       (rs2_busy_out),
        .issue_valid_in     (issue_valid_in),
        .issue_reg_write_in (issue_reg_write_in),
        .issue_rd_in        (issue_rd_in),
        .issue_ready_out    (issue_ready_out),
        .wb_reg_write_in    (wb_reg_write_in),
        .wb_rd_in           (wb_rd_in),
        .wb_data_in         (wb_data_in),
        .sb_error_out       (sb_error_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (wb_reg_write_in && int'(wb_rd_in) == a) return wb_data_in;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input int a);
        int pend;
        if (a == 0) return 1'b0;
        pend = m_cnt[a];
        if (wb_reg_write_in && int'(wb_rd_in) == a) pend = pend - 1;
        return pend > 0;
    endfunction

    // Checks outputs for the inputs already driven, then clocks and advances the model.
    task automatic cycle(input bit check_en);
        int  ird, wrd;
        bit  ready, acc;
        #1;
        ird   = int'(issue_rd_in);
        wrd   = int'(wb_rd_in);
        ready = !issue_reg_write_in || (m_cnt[ird] < MAX_INFLIGHT);
        if (check_en) begin
            chk("rs1_data", rs1_data_out, m_read(int'(rs1_addr_in)));
            chk("rs2_data", rs2_data_out, m_read(int'(rs2_addr_in)));
            chk("rs1_busy", 32'(rs1_busy_out), 32'(m_busy(int'(rs1_addr_in))));
            chk("rs2_busy", 32'(rs2_busy_out), 32'(m_busy(int'(rs2_addr_in))));
            chk("issue_ready", 32'(issue_ready_out), 32'(ready));
            chk("sb_error", 32'(sb_error_out), 32'(m_err));
        end
        acc = issue_valid_in && issue_reg_write_in && ird != 0 && ready;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_cnt[i]  = 0;
            end
            m_err = 1'b0;
        end else begin
            if (wb_reg_write_in && wrd != 0) m_regs[wrd] = wb_data_in;
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                if (acc) m_cnt[ird] = m_cnt[ird] + 1;
                if (wb_reg_write_in && wrd != 0) begin
                    if (m_cnt[wrd] == 0 && !(acc && ird == wrd)) m_err = 1'b1;
                    else if (m_cnt[wrd] > 0) m_cnt[wrd] = m_cnt[wrd] - 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; flush_in = 0;
        issue_valid_in = 0; issue_reg_write_in = 0; issue_rd_in = 0;
        wb_reg_write_in = 0; wb_rd_in = 0; wb_data_in = 0;
    endtask

    task automatic issue(input int rd);
        idle();
        issue_valid_in = 1; issue_reg_write_in = 1; issue_rd_in = REG_BITS'(rd);
    endtask

    task automatic wb(input int rd, input logic [31:0] d);
        wb_reg_write_in = 1; wb_rd_in = REG_BITS'(rd); wb_data_in = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_cnt[i]  = 0;
        end
        m_err = 0;
        idle();
        rs1_addr_in = 0; rs2_addr_in = 0;
        @(negedge clk);
        reset = 1;
        cycle(0);
        reset = 0;

        for (int i = 0; i < 32; i++) begin
            rs1_addr_in = REG_BITS'(i); rs2_addr_in = REG_BITS'(31 - i);
            issue_rd_in = REG_BITS'(i); issue_reg_write_in = 1;
            cycle(1);
        end

        // Issue then write-back with bypass, then array read.
        issue(5); rs1_addr_in = 5; rs2_addr_in = 0;
        cycle(1);
        idle(); wb(5, 32'hDEADBEEF);
        #1 chk("bypass_5", rs1_data_out, 32'hDEADBEEF);
        chk("bypass_5_busy", 32'(rs1_busy_out), 0);
        cycle(1);
        idle();
        #1 chk("array_5", rs1_data_out, 32'hDEADBEEF);
        cycle(1);

        // Fill x7 to the in-flight limit.
        for (int k = 0; k < 4; k++) begin issue(7); rs1_addr_in = 7; cycle(1); end
        idle(); issue_reg_write_in = 1; issue_rd_in = 7;
        #1 chk("ready_7_full", 32'(issue_ready_out), 0);
        issue_rd_in = 8;
        #1 chk("ready_8", 32'(issue_ready_out), 1);
        cycle(1);
        issue(7); cycle(1);
        for (int k = 0; k < 4; k++) begin idle(); wb(7, 32'(k + 100)); cycle(1); end
        idle(); rs1_addr_in = 7;
        #1 chk("busy_7_drained", 32'(rs1_busy_out), 0);
        cycle(1);

        // Same-cycle issue and write-back on x3.
        issue(3); cycle(1);
        issue(3); wb(3, 32'h33); cycle(1);
        idle(); rs1_addr_in = 3;
        #1 chk("busy_3", 32'(rs1_busy_out), 1);
        cycle(1);
        idle(); wb(3, 32'h34); cycle(1);

        // Write-back to x0 is dropped.
        idle(); wb(0, 32'h1234); rs1_addr_in = 0; cycle(1);
        idle(); cycle(1);

        // Flush with concurrent write-back.
        issue(9); cycle(1);
        issue(9); cycle(1);
        idle(); flush_in = 1; wb(9, 32'h55); cycle(1);
        idle(); rs1_addr_in = 9; issue_reg_write_in = 1; issue_rd_in = 9;
        #1 chk("flush_data_9", rs1_data_out, 32'h55);
        chk("flush_busy_9", 32'(rs1_busy_out), 0);
        chk("flush_err", 32'(sb_error_out), 0);
        cycle(1);
        idle(); wb(9, 32'h56); cycle(1);
        idle();
        #1 chk("underflow_err", 32'(sb_error_out), 1);
        cycle(1);

        // Random traffic on a narrow register window to create collisions.
        idle(); reset = 1; cycle(1);
        for (int n = 0; n < 600; n++) begin
            idle();
            reset              = ($urandom_range(0, 99) == 0);
            flush_in           = ($urandom_range(0, 19) == 0);
            issue_valid_in     = $urandom_range(0, 1);
            issue_reg_write_in = ($urandom_range(0, 3) != 0);
            issue_rd_in        = REG_BITS'($urandom_range(0, 5));
            wb_reg_write_in    = ($urandom_range(0, 2) == 0);
            wb_rd_in           = REG_BITS'($urandom_range(0, 5));
            wb_data_in         = $urandom;
            rs1_addr_in        = REG_BITS'($urandom_range(0, 6));
            rs2_addr_in        = REG_BITS'($urandom_range(0, 6));
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
